// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM receive path: PCM width and CIC accumulator sizing.
package pdm_pkg;

  localparam int PCM_W = 10;

  // Accumulator width for a 2nd-order CIC: the output range 0..decim^2 needs one bit above 2*log2(decim).
  function automatic int cic_acc_w(input int decim);
    return 2 * $clog2(decim) + 1;
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM bit-clock generator: 50% duty divided clock plus a one-cycle tick on the last high-phase cycle.
module pdm_clk_gen #(
  parameter  int CLK_DIV = 24,
  localparam int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  output logic pdm_clk,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             pdm_clk_q, pdm_clk_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;
    // Decoded from the next count so pdm_clk lines up with div_cnt without an extra cycle of lag.
    pdm_clk_d = (div_cnt_d >= CNT_HALF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= pdm_clk_d;
    end
  end

  assign pdm_clk = pdm_clk_q;
  assign tick    = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/pdm_decimator.sv
// PDM receiver: synchronizes the bit stream, samples it on the divided tick and decimates with a 2nd-order CIC.
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter  int CLK_DIV = 24,
  parameter  int DECIM   = 32,
  localparam int OUT_W   = 2 * $clog2(DECIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_in,
  output logic             pdm_clk,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid
);

  localparam int ACC_W  = cic_acc_w(DECIM);
  localparam int DCNT_W = $clog2(DECIM);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

  logic              tick;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [ACC_W-1:0]  i1_q, i1_d;
  logic [ACC_W-1:0]  i2_q, i2_d;
  logic [ACC_W-1:0]  i2_dly_q, i2_dly_d;
  logic [ACC_W-1:0]  c1_dly_q, c1_dly_d;
  logic [OUT_W-1:0]  sample_q, sample_d;
  logic              valid_q, valid_d;
  logic [ACC_W-1:0]  c1, c2;
  logic              win_close;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .pdm_clk (pdm_clk),
    .tick    (tick)
  );

  always_comb begin
    sync1_d   = pdm_in;
    sync2_d   = sync1_q;
    dcnt_d    = dcnt_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    i2_dly_d  = i2_dly_q;
    c1_dly_d  = c1_dly_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    win_close = tick && (dcnt_q == DCNT_LAST);

    if (tick) begin
      i1_d   = i1_q + {{(ACC_W-1){1'b0}}, sync2_q};
      i2_d   = i2_q + i1_q;
      dcnt_d = dcnt_q + 1'b1;
    end

    // The comb runs off the integrator's next value so the strobe lands one cycle after the closing tick.
    c1 = i2_d - i2_dly_q;
    c2 = c1 - c1_dly_q;

    if (win_close) begin
      i2_dly_d = i2_d;
      c1_dly_d = c1;
      valid_d  = 1'b1;
      // c2 tops out at exactly DECIM^2, the only value with the MSB set, so clamp it to full scale.
      sample_d = c2[ACC_W-1] ? '1 : c2[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dcnt_q   <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      i2_dly_q <= '0;
      c1_dly_q <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      dcnt_q   <= dcnt_d;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      i2_dly_q <= i2_dly_d;
      c1_dly_q <= c1_dly_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Receive side of the PDM audio/DAC path: takes a 1-bit pulse-density stream and recovers multi-bit PCM samples.
- Generates the PDM bit clock for an external source, or paces the on-chip pdm modulator output.
- Samples the bit on a divided tick and filters it with a 2nd-order CIC decimator.
- Emits an unsigned sample plus a one-cycle valid strobe, in the same 10-bit format sine_gen/pdm use.

Parameters:
- CLK_DIV, 24, clk cycles per PDM bit (even, >=2; 48 MHz/24 = 2 MHz bit clock).
- DECIM, 32, PDM bits per output sample (power of two, >=4).
- OUT_W, 2*log2(DECIM) (=10), derived localparam: output sample width.
- ACC_W, OUT_W+1 (=11), derived localparam: integrator/comb width.

Ports:
- clk  input  1  system clock (SB_HFOSC 48 MHz domain).
- rst_n  input  1  synchronous active-low reset.
- pdm_in  input  1  PDM data bit, asynchronous to clk.
- pdm_clk  output  1  generated PDM bit clock.
- sample  output  OUT_W  decoded unsigned PCM sample.
- sample_valid  output  1  one-cycle strobe; sample updated on this cycle.

Behaviour:
- One clock, clk; reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset values: all counters, integrators, comb delays and synchronizer flops cleared; pdm_clk=0, sample=0, sample_valid=0. Reset mid-window discards the partial window, and the next window starts fresh.
- Input sync: pdm_in passes a 2-flop synchronizer; only the synchronized bit is used.
- Divider (div_cnt, 0..CLK_DIV-1, wraps):
  - pdm_clk = 1 while div_cnt >= CLK_DIV/2, else 0 (registered).
  - tick = (div_cnt == CLK_DIV-1), i.e. the last cycle of the high phase.
- Integrators, updated on tick only, modulo 2^ACC_W with wrap intended:
  - i1 <= i1 + bit.
  - i2 <= i2 + i1, using the old i1.
- Decimation counter dcnt (0..DECIM-1) increments on tick. A tick with dcnt==DECIM-1 closes the window.
- Comb stage, on the clk edge after a window-closing tick:
  - c1 = i2 - i2_d; c2 = c1 - c1_d (mod 2^ACC_W).
  - Then i2_d <= i2 and c1_d <= c1.
  - The same edge registers sample and sets sample_valid for exactly one cycle.
- Saturation: c2 lies in 0..DECIM^2. If c2[ACC_W-1] is set (value DECIM^2), sample = 2^OUT_W-1; otherwise sample = c2[OUT_W-1:0].
- sample holds between strobes. sample_valid never asserts twice within a window.
- Latency: sample_valid is 1 clk after the window-closing tick. The first strobe after reset comes after DECIM ticks.
- Step response (constant bit from reset, DECIM=32):
  - 1st sample 496 (DECIM*(DECIM-1)/2).
  - 2nd and later samples 1024, saturated to 1023.
- Constant 0 yields 0 for all samples.

Decomposition:
- Package pdm_pkg: PCM_W=10 (shared with sine_gen/pdm) and a clog2-based ACC_W helper function.
- One sub-module, pdm_clk_gen: div_cnt, pdm_clk and tick generation. It is reusable by the pdm transmitter for a matching bit rate.
- CIC integrator/comb logic stays inline.

Test Plan:
1. Clock/tick check: rst_n low 4 clk, then release with pdm_in=0 -> pdm_clk period 24 clk, 50% duty, first rising edge 12 clk after release; sample=0 and a strobe every 768 clk.
2. Step input: pdm_in=1 constant after reset -> 1st strobe sample=496, 2nd and all later 1023 (saturated); strobes spaced 768 clk.
3. Alternating bits: pdm_in toggled every tick (1010...) -> after 3rd strobe, sample=512 ±1 for all subsequent strobes.
4. Loopback: pdm modulator driven with constant 10-bit 256, its dout into pdm_in -> settled sample 256 ±4.
5. Reset mid-window: pdm_in=1, assert rst_n low for 1 clk at dcnt=17 -> sample=0 and sample_valid=0 next cycle; the next strobe comes 768 clk after release and the first sample again equals 496.
6. Wrap check: pdm_in=1 held for 10,000 samples -> sample stays 1023, never drops despite integrator wrap.
